// File: rtl/dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory responder slice.
//   - state_t     : responder FSM encoding (IDLE / BUSY / RESP)
//   - WORD_BYTES  : bytes per storage word (and byte-enable width)
//   - WORD_BITS   : bits per storage word
//   - is_err()    : misalignment / range check for a byte address
// ---------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_BITS  = 8 * WORD_BYTES;

    // An access is in error when the byte address is not word aligned or
    // its word index lies beyond the storage. All upper address bits take
    // part in the comparison, so a large address can never alias into range.
    function automatic logic is_err(input logic [63:0] addr, input logic [63:0] depth);
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Request / response channel between the pipeline MEM stage (master) and
//   the data-memory responder (slave). Both channels use valid/ready.
//   Request : req_valid, req_ready, req_write, req_addr[AW], req_wdata[32],
//             req_be[4]
//   Response: rsp_valid, rsp_ready, rsp_rdata[32], rsp_err
// ---------------------------------------------------------------------------
interface dmem_responder_if
    import dmem_pkg::*;
#(
    parameter int AW = 32
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [AW-1:0]         req_addr;
    logic [WORD_BITS-1:0]  req_wdata;
    logic [WORD_BYTES-1:0] req_be;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WORD_BITS-1:0]  rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// ---------------------------------------------------------------------------
// dmem_array
//   DEPTH_WORDS x 32-bit word storage with a synchronous byte-enabled write
//   and a combinational read, both on the same word index. No reset: the
//   contents survive a responder reset.
//   Ports:
//     clock   - write clock
//     wrEn    - commit enabled bytes of wrData to word 'index' at posedge
//     index   - word index for both read and write
//     wrData  - write data
//     wrBe    - per-byte write enables (bit i covers wrData[8i+7:8i])
//     rdData  - current contents of word 'index' (0 if index is past depth)
// ---------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IW          = 8
) (
    input  logic                  clock,
    input  logic                  wrEn,
    input  logic [IW-1:0]         index,
    input  logic [WORD_BITS-1:0]  wrData,
    input  logic [WORD_BYTES-1:0] wrBe,
    output logic [WORD_BITS-1:0]  rdData
);

    logic [WORD_BITS-1:0] mem [DEPTH_WORDS];
    logic                 inRange;

    // Guards non-power-of-two depths where the index can point past the end.
    assign inRange = (32'(index) < 32'(DEPTH_WORDS));

    // Byte-lane write: lanes with a clear enable keep their old contents.
    always_ff @(posedge clock) begin
        if (wrEn && inRange) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (wrBe[b]) begin
                    mem[index][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

    assign rdData = inRange ? mem[index] : '0;

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Target-side data memory for the pipeline MEM stage. Accepts one load or
//   store at a time, spends WAIT_CYCLES cycles in BUSY, then presents the
//   response until the initiator takes it. Misaligned and out-of-range
//   accesses complete with rsp_err=1, rsp_rdata=0 and no storage change.
//   Ports:
//     clock    - single clock, all state on posedge
//     reset_n  - synchronous active-low reset (storage is not cleared)
//     bus      - dmem_responder_if slave modport (request + response)
//   Parameters:
//     DEPTH_WORDS - number of 32-bit words
//     WAIT_CYCLES - BUSY cycles between accept and response (0 allowed)
//     AW          - request address width (must match the interface)
// ---------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    dmem_responder_if.slave   bus
);

    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t                state;
    state_t                nextState;
    logic [CW-1:0]         waitCount;

    logic                  holdWrite;
    logic [AW-1:0]         holdAddr;
    logic [WORD_BITS-1:0]  holdWdata;
    logic [WORD_BYTES-1:0] holdBe;

    logic [WORD_BITS-1:0]  rspRdata;
    logic                  rspErr;

    logic                  accept;
    logic                  enterResp;
    logic                  curWrite;
    logic [AW-1:0]         curAddr;
    logic [WORD_BITS-1:0]  curWdata;
    logic [WORD_BYTES-1:0] curBe;
    logic                  curErr;
    logic [IW-1:0]         curIndex;
    logic                  arrayWrEn;
    logic [WORD_BITS-1:0]  arrayRdata;

    assign accept = (state == IDLE) && bus.req_valid;

    // The access being completed. With zero wait states RESP is entered on
    // the accept edge itself, before the holding registers are loaded, so
    // in IDLE the live request fields are used instead of the held ones.
    assign curWrite = (state == IDLE) ? bus.req_write : holdWrite;
    assign curAddr  = (state == IDLE) ? bus.req_addr  : holdAddr;
    assign curWdata = (state == IDLE) ? bus.req_wdata : holdWdata;
    assign curBe    = (state == IDLE) ? bus.req_be    : holdBe;

    assign curErr   = is_err(64'(curAddr), 64'(DEPTH_WORDS));
    assign curIndex = curAddr[IW+1:2];

    // Commit on the RESP-entry edge; a reset on that edge drops the store.
    assign arrayWrEn = enterResp && curWrite && !curErr && reset_n;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IW          (IW)
    ) arrayInst (
        .clock  (clock),
        .wrEn   (arrayWrEn),
        .index  (curIndex),
        .wrData (curWdata),
        .wrBe   (curBe),
        .rdData (arrayRdata)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; enterResp marks the edge on which the access
    // completes (storage commit and response capture).
    always_comb begin
        nextState = state;
        enterResp = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        nextState = RESP;
                        enterResp = 1'b1;
                    end else begin
                        nextState = BUSY;
                    end
                end
            end
            BUSY: begin
                if (waitCount == '0) begin
                    nextState = RESP;
                    enterResp = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Wait-state counter: loaded on accept, counts down to zero in BUSY.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            waitCount <= '0;
        end else if (accept) begin
            waitCount <= WAIT_LOAD;
        end else if ((state == BUSY) && (waitCount != '0)) begin
            waitCount <= waitCount - CW'(1);
        end
    end

    // Holding registers snapshot the request so later changes on the bus
    // cannot affect an access already in flight.
    always_ff @(posedge clock) begin
        if (accept) begin
            holdWrite <= bus.req_write;
            holdAddr  <= bus.req_addr;
            holdWdata <= bus.req_wdata;
            holdBe    <= bus.req_be;
        end
    end

    // Response registers: captured on RESP entry, held through
    // back-pressure, cleared by the handshake.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rspRdata <= '0;
            rspErr   <= 1'b0;
        end else if (enterResp) begin
            rspRdata <= (!curWrite && !curErr) ? arrayRdata : '0;
            rspErr   <= curErr;
        end else if ((state == RESP) && bus.rsp_ready) begin
            rspRdata <= '0;
            rspErr   <= 1'b0;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rspRdata;
    assign bus.rsp_err   = rspErr;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Target-side data-memory block that answers load/store requests issued by the pipeline's MEM stage over a valid/ready request channel and a valid/ready response channel. It holds word-organised storage with byte-enable writes and inserts a configurable number of wait states per access. It flags misaligned and out-of-range accesses. It replaces the zero-latency data memory, so the pipeline can be exercised against a memory that answers late and applies back-pressure.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1
WAIT_CYCLES, 2, cycles spent in BUSY between request acceptance and response presentation (0 legal)
AW, 32, request address width

Ports:
clock  input  1  single clock; all state updates on posedge
reset_n  input  1  synchronous active-low reset, sampled on posedge clock
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_addr  input  AW  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables for stores; bit i covers wdata[8i+7:8i]; ignored on loads
rsp_valid  output  1  response available
rsp_ready  input  1  initiator takes the response
rsp_rdata  output  32  load data; 0 for stores and errored accesses
rsp_err  output  1  access was misaligned (addr[1:0]!=0) or out of range

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, req_ready=1 from the next cycle, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Storage contents are not cleared.
- FSM states are IDLE, BUSY and RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture write/addr/wdata/be into holding registers. Then:
  - WAIT_CYCLES>0: load counter=WAIT_CYCLES-1 and go to BUSY.
  - WAIT_CYCLES=0: go directly to RESP.
- BUSY: req_ready=0. Counter decrements each cycle. When the counter is 0, go to RESP on the next edge.
- Entry into RESP (same edge):
  - Compute err = (addr[1:0]!=0) || (addr>>2 >= DEPTH_WORDS).
  - Store without error: commit the enabled bytes to word addr>>2. Disabled bytes are unchanged. be=0000 is a legal no-op.
  - Load without error: rsp_rdata = word addr>>2.
  - Any error: no storage change, rsp_rdata=0, rsp_err=1.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until the handshake. req_ready=0.
  - On rsp_ready=1: return to IDLE and clear rsp_valid/rsp_err/rsp_rdata on that edge.
  - Back-to-back requests are therefore possible no sooner than the cycle after the handshake.
- Latency, accept edge to first rsp_valid cycle: WAIT_CYCLES+1 cycles. Throughput is one access per WAIT_CYCLES+2 cycles with rsp_ready held high.
- req_* inputs are ignored whenever req_ready=0. Changing them after acceptance has no effect.
- A load of a word stored by the previous access returns the new data, because the commit precedes the later read.
- Reset mid-operation: from BUSY, a pending store is dropped (storage unchanged). From RESP, the response is discarded and rsp_valid drops the next cycle.
- Address arithmetic is unsigned. Upper address bits beyond the index are checked, never truncated, so aliasing is impossible.
- rsp_valid and req_ready are never 1 in the same cycle.

Decomposition:
- Shared package dmem_pkg holds:
  - the state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2)
  - WORD_BYTES=4
  - a function is_err(addr, depth)
- One sub-module, dmem_array: DEPTH_WORDS x 32 storage, synchronous byte-enabled write, combinational read. It has no reset. The FSM, counter and holding registers stay in dmem_responder.

Test Plan:
- Store then load, WAIT_CYCLES=2: store addr=0x10, wdata=0xDEADBEEF, be=1111; then load addr=0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid first seen 3 cycles after each accept.
- Byte enables: store 0x11223344 to 0x20 with be=1111, then store 0xAABBCCDD with be=0101, then load 0x20 -> 0x11BB33DD.
- Errors: load addr=0x22 -> rsp_err=1, rdata=0. Store to 0x400 with DEPTH_WORDS=256 -> rsp_err=1, and a following load of 0x0 is unchanged.
- Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stable, req_ready=0 throughout, a req_valid pulse is ignored, and exactly one response follows the handshake.
- WAIT_CYCLES=0: back-to-back loads with rsp_ready=1 -> rsp_valid one cycle after each accept, accepts every 2 cycles.
- Reset in BUSY during a store of 0xCAFEF00D to 0x30 -> after reset, a load of 0x30 returns the prior value, and rsp_valid=0 on the first cycle after reset.
